corr_fetch: RTL and testbench
=============================

# corr_fetch

Correspondence fetch stage directly downstream of the point-projection stage. Takes projected pixel coordinates (u,v) and applies the image bounds check. Issues depth-buffer reads for in-bounds pixels through a valid/ready request port, and returns each point's fetched depth with a hit flag, in input order. The projection stage has no backpressure, so the block absorbs memory stalls in an internal FIFO.

## Interface
- FIFO_DEPTH, 16, pending-request FIFO entries (power of two, ≥4)
- RD_LAT, 2, fixed depth-memory read latency in cycles (≥1)
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock, asynchronous, active-low
- i_valid  in  1  projected point valid
- i_idx_x  in  H_SIZE_BW  u from projection
- i_idx_y  in  V_SIZE_BW  v from projection
- r_width  in  H_SIZE_BW  image width register
- r_height  in  V_SIZE_BW  image height register
- o_rd_valid  out  1  read request valid
- o_rd_addr  out  DEPTH_ADDR_BW  read address = v*r_width + u
- i_rd_ready  in  1  memory accepts request
- i_rd_depth  in  DEPTH_BW  read data, valid exactly RD_LAT cycles after the request handshake
- o_valid  out  1  result valid
- o_idx_x / o_idx_y  out  H_SIZE_BW / V_SIZE_BW  echoed coordinates
- o_depth  out  DEPTH_BW  fetched depth; 0 when o_hit=0
- o_hit  out  1  in-bounds and depth nonzero
- o_overflow  out  1  sticky: a point was dropped on a full FIFO

## Operation
- S1 register, on i_valid:
  - inb = (u < r_width) && (v < r_height).
  - Address computed as v*r_width+u, truncated to DEPTH_ADDR_BW.
  - Saturated or negative projections appear as large values, so they fail inb.
- FIFO push: S1 entry {u, v, addr, inb} when S1 is valid.
  - Push when full (count==FIFO_DEPTH and no pop this cycle) → entry dropped, o_overflow set.
  - A simultaneous pop frees a slot, so push is accepted.
- FIFO head:
  - Head with inb=1 → o_rd_valid=1, o_rd_addr=addr; pop on i_rd_ready.
  - Head with inb=0 → pop unconditionally, no request issued.
- Tag delay line of RD_LAT stages carries {popped, u, v, inb}. OOB entries occupy a slot in the same line, so output order equals input order.
- At the line output, register the result:
  - o_valid=1.
  - o_hit = inb && (i_rd_depth != 0).
  - o_depth = o_hit ? i_rd_depth : 0.
- At most one result per cycle; no output backpressure.
- o_overflow clears only on reset.

## Timing
- Reset values: o_valid, o_rd_valid, o_hit, o_overflow = 0; o_idx_x, o_idx_y, o_rd_addr, o_depth = 0.
- Reset empties the FIFO, S1, and the tag line. Memory responses to pre-reset requests are ignored.
- Point sampled at cycle 0:
  - S1 at cycle 1.
  - FIFO head and o_rd_valid at cycle 2 at the earliest.
  - o_valid at cycle 2+RD_LAT+1 when the FIFO is empty and ready is high. This is the minimum latency; stalls add cycle-for-cycle.
- o_rd_valid is combinational from the FIFO head. o_rd_addr is held stable while o_rd_valid && !i_rd_ready.
- Sustained throughput is 1 point/cycle with i_rd_ready=1.

## Configuration
- CORR_FETCH_DROP_CNT_EN defined: adds output o_drop_cnt [15:0].
  - Counts dropped points and saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the port and counter are absent; o_overflow remains.

## Structure
- RgbdVoConfigPk gains DEPTH_BW, DEPTH_ADDR_BW, and the corr_fetch FIFO entry struct typedef.
- One sub-module: CorrFetchFifo, a synchronous FIFO with push/pop/count/full/empty. The rest stays in corr_fetch.

## Test plan
- r_width=640, r_height=480; point (10,2), memory returns 1234 → o_rd_addr=1290; o_valid at cycle 3+RD_LAT with o_hit=1, o_depth=1234.
- Point (640,0), then (0xFFF,5) → no read issued; two results with o_hit=0, o_depth=0, in order.
- Interleave in/out/in points with i_rd_ready=1 → results in input order, one per cycle, hits and misses correct.
- Hold i_rd_ready=0 for 30 cycles under continuous i_valid, FIFO_DEPTH=16:
  - First 16+1 in S1 are retained, later points are dropped, o_overflow=1.
  - After release, results arrive in order.
  - With CORR_FETCH_DROP_CNT_EN, o_drop_cnt equals the dropped count.
- In-bounds point, memory returns 0 → o_hit=0, o_depth=0.
- Assert i_rst_n low while requests are in flight → all outputs 0 next edge. No o_valid from stale responses after release.

Source files
------------

// File: rtl/corr_fetch_pkg.sv
// corr_fetch shared widths, bundles and helpers.
// Imported by corr_fetch and corr_fetch_fifo.
package corr_fetch_pkg;

  localparam int H_SIZE_BW     = 12;
  localparam int V_SIZE_BW     = 12;
  localparam int DEPTH_BW      = 16;
  localparam int DEPTH_ADDR_BW = 20;

  typedef struct packed {
    logic [H_SIZE_BW-1:0]     u;
    logic [V_SIZE_BW-1:0]     v;
    logic [DEPTH_ADDR_BW-1:0] addr;
    logic                     inb;
  } corr_ent_t;

  typedef struct packed {
    logic                 vld;
    logic [H_SIZE_BW-1:0] u;
    logic [V_SIZE_BW-1:0] v;
    logic                 inb;
  } corr_tag_t;

  function automatic logic in_bounds(
    input logic [H_SIZE_BW-1:0] u,
    input logic [V_SIZE_BW-1:0] v,
    input logic [H_SIZE_BW-1:0] w,
    input logic [V_SIZE_BW-1:0] h
  );
    return (u < w) && (v < h);
  endfunction

endpackage

// File: rtl/corr_fetch_fifo.sv
// Pending-request FIFO for corr_fetch.
// Caller never pushes when full unless it pops in the same cycle.
module corr_fetch_fifo
  import corr_fetch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  corr_ent_t              din,
  output corr_ent_t              dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  corr_ent_t     mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // storage write, no reset needed for payload
  always_ff @(posedge i_clk) begin
    if (push) mem[wptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/corr_fetch.sv
// Correspondence fetch: bounds check, depth read, in-order results.
// Optional CORR_FETCH_DROP_CNT_EN adds a saturating o_drop_cnt.
module corr_fetch
  import corr_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int RD_LAT     = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [H_SIZE_BW-1:0]     i_idx_x,
  input  logic [V_SIZE_BW-1:0]     i_idx_y,
  input  logic [H_SIZE_BW-1:0]     r_width,
  input  logic [V_SIZE_BW-1:0]     r_height,
  output logic                     o_rd_valid,
  output logic [DEPTH_ADDR_BW-1:0] o_rd_addr,
  input  logic                     i_rd_ready,
  input  logic [DEPTH_BW-1:0]      i_rd_depth,
  output logic                     o_valid,
  output logic [H_SIZE_BW-1:0]     o_idx_x,
  output logic [V_SIZE_BW-1:0]     o_idx_y,
  output logic [DEPTH_BW-1:0]      o_depth,
  output logic                     o_hit,
  output logic                     o_overflow
`ifdef CORR_FETCH_DROP_CNT_EN
  ,
  output logic [15:0]              o_drop_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AB = DEPTH_ADDR_BW;

  logic      s1_vld;
  corr_ent_t s1;

  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  logic [CW-1:0] cnt;
  corr_ent_t     head;

  corr_tag_t tag [RD_LAT];
  corr_tag_t last;
  logic      hit;

  // S1: bounds check and linear address
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else begin
      s1_vld <= i_valid;
      if (i_valid) begin
        s1.u    <= i_idx_x;
        s1.v    <= i_idx_y;
        s1.inb  <= in_bounds(i_idx_x, i_idx_y,
                             r_width, r_height);
        s1.addr <= AB'(i_idx_y) * AB'(r_width)
                 + AB'(i_idx_x);
      end
    end
  end

  assign pop  = !empty && (!head.inb || i_rd_ready);
  assign push = s1_vld && (!full || pop);
  assign drop = s1_vld && (cnt == CW'(FIFO_DEPTH)) && !pop;

  corr_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .pop     (pop),
    .din     (s1),
    .dout    (head),
    .count   (cnt),
    .full    (full),
    .empty   (empty)
  );

  assign o_rd_valid = !empty && head.inb;
  assign o_rd_addr  = o_rd_valid ? head.addr : '0;

  // tag line mirrors memory latency, OOB entries ride along
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag[i] <= '0;
    end else begin
      tag[0] <= '{vld: pop, u: head.u,
                  v: head.v, inb: head.inb};
      for (int i = 1; i < RD_LAT; i++) tag[i] <= tag[i-1];
    end
  end

  assign last = tag[RD_LAT-1];
  assign hit  = last.vld && last.inb && (i_rd_depth != '0);

  // result register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_idx_x <= '0;
      o_idx_y <= '0;
      o_hit   <= 1'b0;
      o_depth <= '0;
    end else begin
      o_valid <= last.vld;
      o_hit   <= hit;
      o_depth <= hit ? i_rd_depth : '0;
      if (last.vld) begin
        o_idx_x <= last.u;
        o_idx_y <= last.v;
      end
    end
  end

  // sticky overflow
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_overflow <= 1'b0;
    else if (drop) o_overflow <= 1'b1;
  end

`ifdef CORR_FETCH_DROP_CNT_EN
  // saturating count of dropped points
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_drop_cnt <= '0;
    else if (drop && o_drop_cnt != 16'hFFFF)
      o_drop_cnt <= o_drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_corr_fetch.sv
// Directed bench for corr_fetch.
// Results scored in order against a queue of expected points.
module tb_corr_fetch;
  import corr_fetch_pkg::*;

  localparam int FD = 16;
  localparam int RL = 2;

  logic                     i_clk = 1'b0;
  logic                     i_rst_n = 1'b0;
  logic                     i_valid = 1'b0;
  logic [H_SIZE_BW-1:0]     i_idx_x = '0;
  logic [V_SIZE_BW-1:0]     i_idx_y = '0;
  logic [H_SIZE_BW-1:0]     r_width = 12'd640;
  logic [V_SIZE_BW-1:0]     r_height = 12'd480;
  logic                     o_rd_valid;
  logic [DEPTH_ADDR_BW-1:0] o_rd_addr;
  logic                     i_rd_ready = 1'b1;
  logic [DEPTH_BW-1:0]      i_rd_depth;
  logic                     o_valid;
  logic [H_SIZE_BW-1:0]     o_idx_x;
  logic [V_SIZE_BW-1:0]     o_idx_y;
  logic [DEPTH_BW-1:0]      o_depth;
  logic                     o_hit;
  logic                     o_overflow;
`ifdef CORR_FETCH_DROP_CNT_EN
  logic [15:0]              o_drop_cnt;
`endif

  corr_fetch #(
    .FIFO_DEPTH (FD),
    .RD_LAT     (RL)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_idx_x    (i_idx_x),
    .i_idx_y    (i_idx_y),
    .r_width    (r_width),
    .r_height   (r_height),
    .o_rd_valid (o_rd_valid),
    .o_rd_addr  (o_rd_addr),
    .i_rd_ready (i_rd_ready),
    .i_rd_depth (i_rd_depth),
    .o_valid    (o_valid),
    .o_idx_x    (o_idx_x),
    .o_idx_y    (o_idx_y),
    .o_depth    (o_depth),
    .o_hit      (o_hit),
    .o_overflow (o_overflow)
`ifdef CORR_FETCH_DROP_CNT_EN
    ,
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  // depth memory contents: hand-picked entries plus nonzero fill
  function automatic logic [15:0] mem_fn(input logic [19:0] a);
    if (a == 20'd1290) return 16'd1234;
    if (a == 20'd3207) return 16'd0;
    return a[15:0] + 16'd100;
  endfunction

  // memory model with fixed latency RL
  logic [15:0] mpipe [RL];
  int n_req = 0;
  always @(posedge i_clk) begin
    mpipe[0] <= (o_rd_valid && i_rd_ready) ?
                mem_fn(o_rd_addr) : 16'hBEEF;
    for (int i = 1; i < RL; i++) mpipe[i] <= mpipe[i-1];
    if (o_rd_valid && i_rd_ready) n_req <= n_req + 1;
  end
  assign i_rd_depth = mpipe[RL-1];

  typedef struct {
    int x;
    int y;
    int hit;
    int depth;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  // result scoreboard
  always @(negedge i_clk) begin : mon
    exp_t e;
    if (i_rst_n && o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexp_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_x", 32'(o_idx_x), e.x);
        check("res_y", 32'(o_idx_y), e.y);
        check("res_hit", 32'(o_hit), e.hit);
        check("res_depth", 32'(o_depth), e.depth);
        if (e.cyc >= 0) check("res_cyc", cyc, e.cyc);
      end
    end
  end

  // present one point; called just after a negedge
  task automatic drive(input int x, input int y,
                       input bit keep, input bit tim);
    exp_t e;
    bit   inb;
    int   d;
    i_valid = 1'b1;
    i_idx_x = 12'(x);
    i_idx_y = 12'(y);
    inb = (x < 640) && (y < 480);
    d = inb ? int'(mem_fn(20'(y * 640 + x))) : 0;
    e.x = x;
    e.y = y;
    e.depth = d;
    e.hit = (d != 0) ? 1 : 0;
    e.cyc = tim ? cyc + 3 + RL : -1;
    if (keep) exp_q.push_back(e);
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_rd_valid"}, 32'(o_rd_valid), 0);
    check({tag, "_rd_addr"}, 32'(o_rd_addr), 0);
    check({tag, "_hit"}, 32'(o_hit), 0);
    check({tag, "_depth"}, 32'(o_depth), 0);
    check({tag, "_ovf"}, 32'(o_overflow), 0);
    check({tag, "_x"}, 32'(o_idx_x), 0);
    check({tag, "_y"}, 32'(o_idx_y), 0);
  endtask

  int r0;

  initial begin
    repeat (3) @(negedge i_clk);
    chk_zero("rst");
`ifdef CORR_FETCH_DROP_CNT_EN
    check("rst_drop_cnt", 32'(o_drop_cnt), 0);
`endif
    i_rst_n = 1'b1;
    idle(2);

    // single in-bounds hit, latency and address
    drive(10, 2, 1, 1);
    i_valid = 1'b0;
    @(negedge i_clk);
    check("t1_rd_valid", 32'(o_rd_valid), 1);
    check("t1_rd_addr", 32'(o_rd_addr), 1290);
    idle(8);

    // out of bounds: no reads issued
    r0 = n_req;
    drive(640, 0, 1, 1);
    drive(4095, 5, 1, 1);
    idle(8);
    check("oob_no_req", n_req, r0);

    // interleaved in/out, zero depth, edges
    drive(1, 1, 1, 1);
    drive(700, 3, 1, 1);
    drive(2, 1, 1, 1);
    drive(7, 5, 1, 1);
    drive(3, 479, 1, 1);
    drive(5, 480, 1, 1);
    drive(639, 0, 1, 1);
    idle(10);

    // stall with continuous input: 16 queued, last S1 kept
    i_rd_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 20 || k == 25) begin
        check("stall_rd_valid", 32'(o_rd_valid), 1);
        check("stall_rd_addr", 32'(o_rd_addr), 6400);
      end
      drive(k, 10, (k < 16) || (k == 29), 0);
    end
    i_valid = 1'b0;
    i_rd_ready = 1'b1;
    idle(30);
    check("stall_ovf", 32'(o_overflow), 1);
`ifdef CORR_FETCH_DROP_CNT_EN
    check("stall_drop_cnt", 32'(o_drop_cnt), 13);
`endif
    check("stall_drained", exp_q.size(), 0);

    // reset with requests in flight
    drive(20, 1, 0, 0);
    drive(21, 1, 0, 0);
    drive(22, 1, 0, 0);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(negedge i_clk);
    chk_zero("mid_rst2");
`ifdef CORR_FETCH_DROP_CNT_EN
    check("mid_rst_drop_cnt", 32'(o_drop_cnt), 0);
`endif
    i_rst_n = 1'b1;
    r0 = n_req;
    idle(12);
    check("post_rst_no_req", n_req, r0);

    // operation resumes cleanly
    drive(10, 2, 1, 1);
    idle(8);

    check("final_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
